chunk_unpacker: RTL

//   Receive side of the packed multi-chunk bus that the chunk producers drive.

---
 rtl/chunk_unpacker_if.sv | 43 ++++
 rtl/chunk_unpacker.sv | 99 +++++++++
 2 files changed

// File: rtl/chunk_unpacker_if.sv
// Handshake bundle for chunk_unpacker: packed-word input side, chunk-serial output side and the
// completed-word counter.
interface chunk_unpacker_if #(
  parameter int unsigned CHUNK_W = 11,
  parameter int unsigned CHUNKS  = 5,
  parameter int unsigned IW      = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
);
  logic                        in_valid;
  logic                        in_ready;
  logic [CHUNK_W*CHUNKS-1:0]   in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [CHUNK_W-1:0]          out_data;
  logic [IW-1:0]               out_index;
  logic                        out_last;
  logic [15:0]                 words_done;

  // Producer and sink side.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    input  words_done
  );

  // Unpacker side.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    output words_done
  );
endinterface

// File: rtl/chunk_unpacker.sv
// Loads one packed word of CHUNKS x CHUNK_W bits and replays it one chunk per cycle with
// index/last flags; a new word can be taken on the last chunk's handshake without a bubble.
module chunk_unpacker #(
  parameter int unsigned CHUNK_W   = 11,
  parameter int unsigned CHUNKS    = 5,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  chunk_unpacker_if.slave bus
);

  localparam int unsigned IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int unsigned WW = CHUNK_W * CHUNKS;
  localparam logic [IW-1:0] LastIdx = IW'(CHUNKS - 1);

  typedef enum logic {StIdle, StEmit} state_e;

  state_e           state_q, state_d;
  logic [WW-1:0]    hold_q, hold_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [15:0]      done_q, done_d;

  logic             out_valid;
  logic             out_last;
  logic             fire;
  logic             last_fire;
  logic             in_ready;
  logic             load;
  logic [IW-1:0]    chunk_sel;
  logic [CHUNK_W-1:0] out_data;

  assign out_valid = (state_q == StEmit);
  // Gated by state so an idle unpacker never advertises a last chunk.
  assign out_last  = out_valid && (idx_q == LastIdx);
  assign fire      = out_valid && bus.out_ready;
  assign last_fire = fire && out_last;
  assign in_ready  = (state_q == StIdle) || last_fire;
  assign load      = bus.in_valid && in_ready;

  always_comb begin
    chunk_sel = idx_q;
    if (MSB_FIRST) begin
      chunk_sel = LastIdx - idx_q;
    end
  end

  always_comb begin
    out_data = '0;
    for (int c = 0; c < int'(CHUNKS); c++) begin
      if (chunk_sel == IW'(c)) begin
        out_data = hold_q[c*CHUNK_W +: CHUNK_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    done_d  = done_q;

    if (last_fire) begin
      done_d  = done_q + 16'd1;
      state_d = StIdle;
    end else if (fire) begin
      idx_d = idx_q + IW'(1);
    end

    // A load on the last handshake overrides the return to idle.
    if (load) begin
      hold_d  = bus.in_data;
      idx_d   = '0;
      state_d = StEmit;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      hold_q  <= '0;
      idx_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_data;
  assign bus.out_index  = idx_q;
  assign bus.out_last   = out_last;
  assign bus.words_done = done_q;

endmodule
